// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: sequenced, configurable serial pattern detector.
// Holds the pattern configuration and runs an IDLE -> ARM -> RUN -> DONE
// sequence. In RUN it shifts serial bits into a history register and counts
// overlapping matches until a programmed limit or an abort ends the run.
module pattern_det_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rs,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_pat,
    input  logic [3:0]    cfg_len,
    input  logic [CW-1:0] cfg_limit,
    input  logic          start,
    input  logic          abort,
    input  logic          s,
    input  logic          s_valid,
    output logic          y,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] match_cnt,
    output logic [1:0]    state
);

    localparam int FW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t        st;
    logic [PW-1:0] pat_r;
    logic [3:0]    len_r;
    logic [CW-1:0] limit_r;
    logic [PW-1:0] hist_r;
    logic [FW-1:0] fill_r;
    logic [CW-1:0] cnt_r;
    logic          y_r;
    logic          done_r;
    logic          err_r;

    logic [PW-1:0] hist_nxt;
    logic [PW-1:0] len_mask;
    logic [FW-1:0] fill_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          len_ok;
    logic          hit;

    // Fill count stops at PW: once the history is full it stays full.
    function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
        if (int'(f) >= PW) return f;
        return f + FW'(1);
    endfunction

    // Match counter holds at all-ones instead of wrapping.
    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
        if (&c) return c;
        return c + CW'(1);
    endfunction

    // Mask selecting the low 'l' bits of the history/pattern.
    function automatic logic [PW-1:0] mask_of(input logic [3:0] l);
        logic [PW-1:0] m;
        for (int i = 0; i < PW; i++) m[i] = (i < int'(l));
        return m;
    endfunction

    // Post-shift view of the history used for the match decision on this edge.
    always_comb begin
        hist_nxt = {hist_r[PW-2:0], s};
        fill_nxt = fill_sat_inc(fill_r);
        len_mask = mask_of(len_r);
        cnt_nxt  = cnt_sat_inc(cnt_r);
        len_ok   = (len_r != 4'd0) && (int'(len_r) <= PW);
        hit      = (int'(fill_nxt) >= int'(len_r)) &&
                   ((hist_nxt & len_mask) == (pat_r & len_mask));
    end

    // Sequencer, configuration, history and registered output pulses.
    always_ff @(posedge ck) begin
        if (!rs) begin
            st      <= IDLE;
            pat_r   <= '0;
            len_r   <= '0;
            limit_r <= '0;
            hist_r  <= '0;
            fill_r  <= '0;
            cnt_r   <= '0;
            y_r     <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            y_r    <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (st)
                IDLE: begin
                    // start is judged against the config held before this edge
                    if (start) begin
                        if (len_ok) st <= ARM;
                        else        err_r <= 1'b1;
                    end
                    if (cfg_we) begin
                        pat_r   <= cfg_pat;
                        len_r   <= cfg_len;
                        limit_r <= cfg_limit;
                    end
                end
                ARM: begin
                    if (abort) begin
                        st <= IDLE;
                    end else begin
                        hist_r <= '0;
                        fill_r <= '0;
                        cnt_r  <= '0;
                        st     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (s_valid) begin
                        hist_r <= hist_nxt;
                        fill_r <= fill_nxt;
                        if (hit) begin
                            y_r   <= 1'b1;
                            cnt_r <= cnt_nxt;
                            if ((limit_r != '0) && (cnt_nxt == limit_r)) begin
                                done_r <= 1'b1;
                                st     <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign y         = y_r;
    assign done      = done_r;
    assign err       = err_r;
    assign match_cnt = cnt_r;
    assign state     = st;
    assign busy      = (st == ARM) || (st == RUN);

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Testbench for pattern_det_ctrl: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a bit-list reference model.
module tb_pattern_det_ctrl;

    localparam int PW = 8;
    localparam int CW = 8;

    logic          ck;
    logic          rs;
    logic          cfg_we;
    logic [PW-1:0] cfg_pat;
    logic [3:0]    cfg_len;
    logic [CW-1:0] cfg_limit;
    logic          start;
    logic          abort;
    logic          s;
    logic          s_valid;
    logic          y;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] match_cnt;
    logic [1:0]    state;

    pattern_det_ctrl #(.PW(PW), .CW(CW)) dut (
        .ck(ck), .rs(rs), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_limit(cfg_limit), .start(start),
        .abort(abort), .s(s), .s_valid(s_valid), .y(y), .busy(busy),
        .done(done), .err(err), .match_cnt(match_cnt), .state(state)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 arm, 2 run, 3 done; bits received in a list.
    int      m_ph;
    int      m_pat;
    int      m_len;
    int      m_limit;
    int      m_cnt;
    bit      m_y, m_done, m_err;
    bit      bits[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        int n;
        n = bits.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (bits[n - 1 - i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (!rs) begin
            m_ph = 0; m_pat = 0; m_len = 0; m_limit = 0; m_cnt = 0;
            m_y = 0; m_done = 0; m_err = 0;
            bits.delete();
            return;
        end
        m_y = 0; m_done = 0; m_err = 0;
        case (m_ph)
            0: begin
                if (start) begin
                    if (m_len == 0 || m_len > PW) m_err = 1;
                    else m_ph = 1;
                end
                if (cfg_we) begin
                    m_pat = int'(cfg_pat); m_len = int'(cfg_len); m_limit = int'(cfg_limit);
                end
            end
            1: begin
                if (abort) m_ph = 0;
                else begin
                    bits.delete();
                    m_cnt = 0;
                    m_ph = 2;
                end
            end
            2: begin
                if (abort) m_ph = 0;
                else if (s_valid) begin
                    bits.push_back(s);
                    if (bits.size() > PW) void'(bits.pop_front());
                    if (model_hit()) begin
                        m_y = 1;
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
                        if (m_limit != 0 && m_cnt == m_limit) begin
                            m_done = 1;
                            m_ph = 3;
                        end
                    end
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge ck);
        #1;
        chk("state", state, m_ph);
        chk("busy", busy, (m_ph == 1 || m_ph == 2));
        chk("y", y, m_y);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("match_cnt", match_cnt, m_cnt);
    endtask

    task automatic do_cfg(input logic [PW-1:0] p, input logic [3:0] l, input logic [CW-1:0] lim);
        cfg_we = 1; cfg_pat = p; cfg_len = l; cfg_limit = lim;
        tick();
        cfg_we = 0;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        s = b; s_valid = 1;
        tick();
        s_valid = 0;
    endtask

    task automatic send_seq(input logic [15:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(seq[i]);
    endtask

    initial begin
        rs = 0; cfg_we = 0; cfg_pat = '0; cfg_len = '0; cfg_limit = '0;
        start = 0; abort = 0; s = 0; s_valid = 0;

        // reset
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_cnt", match_cnt, 0);
        rs = 1;

        // 1: basic 6-bit pattern
        do_cfg(8'b00101011, 4'd6, 8'd0);
        go();
        send_seq(16'b101011, 6);
        chk("s1_y", y, 1);
        chk("s1_cnt", match_cnt, 1);
        abort = 1; tick(); abort = 0;

        // 2: overlap
        do_cfg(8'b00000101, 4'd3, 8'd0);
        go();
        send_seq(16'b10101, 5);
        chk("s2_cnt", match_cnt, 2);
        abort = 1; tick(); abort = 0;

        // 3: limit reached, later bits ignored
        do_cfg(8'b00000101, 4'd3, 8'd2);
        go();
        send_seq(16'b10101, 5);
        chk("s3_done", done, 1);
        chk("s3_y", y, 1);
        tick();
        chk("s3_state", state, 0);
        chk("s3_busy", busy, 0);
        send_seq(16'b0101, 4);
        chk("s3_cnt_hold", match_cnt, 2);

        // 4: illegal length
        do_cfg(8'b00000101, 4'd0, 8'd0);
        start = 1; tick(); start = 0;
        chk("s4_err", err, 1);
        chk("s4_state", state, 0);
        tick();
        chk("s4_err_clr", err, 0);

        // 5: abort on completing bit; cfg_we during RUN ignored
        do_cfg(8'b00000101, 4'd3, 8'd0);
        go();
        send_seq(16'b101, 3);
        cfg_we = 1; cfg_pat = 8'b00011111; cfg_len = 4'd5;
        send_bit(0);
        cfg_we = 0;
        abort = 1; s = 1; s_valid = 1;
        tick();
        abort = 0; s_valid = 0;
        chk("s5_y", y, 0);
        chk("s5_cnt", match_cnt, 1);
        chk("s5_state", state, 0);
        go();
        send_seq(16'b101, 3);
        chk("s5_cfg_kept", match_cnt, 1);

        // 6: reset mid-run
        abort = 1; tick(); abort = 0;
        go();
        send_seq(16'b1010101, 7);
        chk("s6_cnt3", match_cnt, 3);
        rs = 0; tick(); rs = 1;
        chk("s6_cnt", match_cnt, 0);
        chk("s6_state", state, 0);
        start = 1; tick(); start = 0;
        chk("s6_err", err, 1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rs        = ($urandom_range(0, 199) != 0);
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_pat   = PW'($urandom);
            cfg_len   = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) cfg_len = 4'd9;
            cfg_limit = CW'($urandom_range(0, 3));
            start     = ($urandom_range(0, 4) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            s         = 1'($urandom);
            s_valid   = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
